// File: rtl/sdram_req_arb_pkg.sv
// Shared definitions for the SDRAM request arbiter: FSM state encodings and default refresh period.
package sdram_req_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REF  = 2'd1,
    ARB_WR   = 2'd2,
    ARB_RD   = 2'd3
  } arb_state_t;

  // 7.8 us at 100 MHz
  localparam int REF_PERIOD_DEF = 781;

endpackage

// File: rtl/sdram_ref_timer.sv
// Periodic refresh timer with a saturating (0..3) count of owed refreshes.
// Counter and backlog only run while init_done is high and clear when it drops.
module sdram_ref_timer
  import sdram_req_arb_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_done,
  input  logic ref_ack,
  output logic ref_req
);

  localparam int CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    pend;
  logic          wrap;

  assign wrap    = init_done && (cnt == CW'(REF_PERIOD - 1));
  assign ref_req = (pend != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      pend <= 2'd0;
    end else if (!init_done) begin
      cnt  <= '0;
      pend <= 2'd0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      // a wrap and an ack in the same cycle cancel out
      if (wrap && !ref_ack && pend != 2'd3)
        pend <= pend + 2'd1;
      else if (!wrap && ref_ack && pend != 2'd0)
        pend <= pend - 2'd1;
    end
  end

endmodule

// File: rtl/sdram_req_arb.sv
// Grants one SDRAM operation at a time: refresh first, then write/read round-robin.
// Grant is registered (go one cycle after the request is sampled); busy states hold until ctrl_done.
module sdram_req_arb
  import sdram_req_arb_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF,
  parameter int ADDR_W     = 24,
  parameter int BURST_W    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_done,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [BURST_W-1:0] wr_burst,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  input  logic [BURST_W-1:0] rd_burst,
  output logic               wr_done,
  output logic               rd_done,
  output logic               ctrl_rd_wr,
  output logic [ADDR_W-1:0]  ctrl_addr,
  output logic [BURST_W-1:0] ctrl_burst,
  output logic               ctrl_wr_go,
  output logic               ctrl_rd_go,
  output logic               ctrl_ref_go,
  input  logic               ctrl_done
);

  arb_state_t state, nxt_state;
  logic       last_rd;
  logic       ref_req;
  logic       wr_vld, rd_vld;
  logic       grant_ref, grant_wr, grant_rd;
  logic       op_end;

  assign wr_vld = wr_req && (wr_burst != '0);
  assign rd_vld = rd_req && (rd_burst != '0);
  // a done coinciding with the go pulse belongs to no operation of ours
  assign op_end = ctrl_done && !(ctrl_wr_go || ctrl_rd_go || ctrl_ref_go);

  sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .ref_ack   (grant_ref),
    .ref_req   (ref_req)
  );

  always_comb begin
    nxt_state = state;
    grant_ref = 1'b0;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (init_done) begin
          if (ref_req)               grant_ref = 1'b1;
          else if (wr_vld && rd_vld) begin
            grant_wr = last_rd;
            grant_rd = !last_rd;
          end
          else if (wr_vld)           grant_wr = 1'b1;
          else if (rd_vld)           grant_rd = 1'b1;
        end
        if (grant_ref)     nxt_state = ARB_REF;
        else if (grant_wr) nxt_state = ARB_WR;
        else if (grant_rd) nxt_state = ARB_RD;
      end
      default: begin
        if (op_end) nxt_state = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      last_rd     <= 1'b1;
      ctrl_rd_wr  <= 1'b0;
      ctrl_addr   <= '0;
      ctrl_burst  <= '0;
      ctrl_wr_go  <= 1'b0;
      ctrl_rd_go  <= 1'b0;
      ctrl_ref_go <= 1'b0;
      wr_done     <= 1'b0;
      rd_done     <= 1'b0;
    end else begin
      state       <= nxt_state;
      ctrl_wr_go  <= grant_wr;
      ctrl_rd_go  <= grant_rd;
      ctrl_ref_go <= grant_ref;
      wr_done     <= (state == ARB_WR) && op_end;
      rd_done     <= (state == ARB_RD) && op_end;
      if (grant_wr) begin
        ctrl_addr  <= wr_addr;
        ctrl_burst <= wr_burst;
        ctrl_rd_wr <= 1'b0;
        last_rd    <= 1'b0;
      end else if (grant_rd) begin
        ctrl_addr  <= rd_addr;
        ctrl_burst <= rd_burst;
        ctrl_rd_wr <= 1'b1;
        last_rd    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_req_arb.sv
// Directed bench for sdram_req_arb: refresh timing, round-robin, zero bursts, stall backlog, init drop, reset.
module tb_sdram_req_arb;

  localparam logic [2:0] K_REF = 3'b100;
  localparam logic [2:0] K_WR  = 3'b010;
  localparam logic [2:0] K_RD  = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic        wr_req, rd_req;
  logic [23:0] wr_addr, rd_addr;
  logic [9:0]  wr_burst, rd_burst;
  logic        wr_done, rd_done;
  logic        ctrl_rd_wr;
  logic [23:0] ctrl_addr;
  logic [9:0]  ctrl_burst;
  logic        ctrl_wr_go, ctrl_rd_go, ctrl_ref_go;
  logic        ctrl_done;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdram_req_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_done  (init_done),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_burst   (wr_burst),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_burst   (rd_burst),
    .wr_done    (wr_done),
    .rd_done    (rd_done),
    .ctrl_rd_wr (ctrl_rd_wr),
    .ctrl_addr  (ctrl_addr),
    .ctrl_burst (ctrl_burst),
    .ctrl_wr_go (ctrl_wr_go),
    .ctrl_rd_go (ctrl_rd_go),
    .ctrl_ref_go(ctrl_ref_go),
    .ctrl_done  (ctrl_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] gos();
    return {ctrl_ref_go, ctrl_wr_go, ctrl_rd_go};
  endfunction

  // Looks at the current negedge sample first, then steps up to max cycles.
  task automatic wait_go(input int max, output logic f, output logic [2:0] g);
    int n = 0;
    f = 1'b0;
    g = gos();
    while (g == 3'b000 && n < max) begin
      @(negedge clk);
      n++;
      g = gos();
    end
    f = (g != 3'b000);
  endtask

  // Runs one granted operation; returns at the negedge where the done pulse is visible.
  task automatic do_op(input string tag, input logic [2:0] ek, input logic [23:0] ea,
                       input logic [9:0] eb, input logic erw, input int hold,
                       input bit early, output int gc);
    logic       f;
    logic [2:0] g;
    int         busy_go = 0;
    wait_go(2000, f, g);
    gc = cyc;
    chk({tag, "_found"}, 32'(f), 32'(1));
    chk({tag, "_kind"}, 32'(g), 32'(ek));
    chk({tag, "_addr"}, 32'(ctrl_addr), 32'(ea));
    chk({tag, "_burst"}, 32'(ctrl_burst), 32'(eb));
    chk({tag, "_rdwr"}, 32'(ctrl_rd_wr), 32'(erw));
    chk({tag, "_done_clr"}, 32'({wr_done, rd_done}), 32'(0));
    if (early) ctrl_done = 1'b1;
    @(negedge clk);
    ctrl_done = 1'b0;
    chk({tag, "_go_width"}, 32'(gos()), 32'(0));
    chk({tag, "_no_early_done"}, 32'({wr_done, rd_done}), 32'(0));
    repeat (hold) begin
      @(negedge clk);
      if (gos() != 3'b000) busy_go++;
    end
    chk({tag, "_busy_nogo"}, 32'(busy_go), 32'(0));
    chk({tag, "_addr_hold"}, 32'(ctrl_addr), 32'(ea));
    ctrl_done = 1'b1;
    @(negedge clk);
    ctrl_done = 1'b0;
    chk({tag, "_wr_done"}, 32'(wr_done), 32'(ek[1]));
    chk({tag, "_rd_done"}, 32'(rd_done), 32'(ek[0]));
  endtask

  initial begin
    int         c0, gc1, gc2, gd;
    logic       f;
    logic [2:0] g;

    rst_n = 1'b0; init_done = 1'b0; ctrl_done = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = 24'h0; rd_addr = 24'h0; wr_burst = 10'd0; rd_burst = 10'd0;
    repeat (3) @(negedge clk);
    chk("rst_gos", 32'(gos()), 32'(0));
    chk("rst_dones", 32'({wr_done, rd_done}), 32'(0));
    chk("rst_rdwr", 32'(ctrl_rd_wr), 32'(0));
    chk("rst_addr", 32'(ctrl_addr), 32'(0));
    chk("rst_burst", 32'(ctrl_burst), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // refresh only: first go 782 cycles after init_done, then every 781
    init_done = 1'b1;
    c0 = cyc;
    do_op("ref1", K_REF, 24'h0, 10'd0, 1'b0, 1, 1'b0, gc1);
    chk("ref1_time", 32'(gc1 - c0), 32'(782));
    do_op("ref2", K_REF, 24'h0, 10'd0, 1'b0, 1, 1'b0, gc2);
    chk("ref_interval", 32'(gc2 - gc1), 32'(781));

    // both requesters pending: WR, RD, WR, RD; first op also sees a done during its go cycle
    wr_addr = 24'h10_0000; wr_burst = 10'd16;
    rd_addr = 24'h20_0000; rd_burst = 10'd32;
    wr_req = 1'b1; rd_req = 1'b1;
    do_op("rr1", K_WR, 24'h10_0000, 10'd16, 1'b0, 19, 1'b1, gd);
    wr_addr = 24'h10_0010;
    do_op("rr2", K_RD, 24'h20_0000, 10'd32, 1'b1, 19, 1'b0, gd);
    rd_addr = 24'h20_0020;
    do_op("rr3", K_WR, 24'h10_0010, 10'd16, 1'b0, 19, 1'b0, gd);
    do_op("rr4", K_RD, 24'h20_0020, 10'd32, 1'b1, 19, 1'b0, gd);

    // zero-length write burst is not a request
    wr_burst = 10'd0;
    rd_addr = 24'h30_0000; rd_burst = 10'd8;
    do_op("z1", K_RD, 24'h30_0000, 10'd8, 1'b1, 3, 1'b0, gd);
    do_op("z2", K_RD, 24'h30_0000, 10'd8, 1'b1, 3, 1'b0, gd);
    wr_req = 1'b0; rd_req = 1'b0;

    // refresh keeps the latched fields from the last data grant
    do_op("ref3", K_REF, 24'h30_0000, 10'd8, 1'b1, 1, 1'b0, gd);
    wait_go(400, f, g);
    chk("idle_nogo", 32'(f), 32'(0));

    // long write spans a refresh wrap; refresh goes next, then RD stalls for 4 periods
    wr_addr = 24'h01_2345; wr_burst = 10'd64;
    rd_addr = 24'h02_0000; rd_burst = 10'd100;
    wr_req = 1'b1; rd_req = 1'b1;
    do_op("long_wr", K_WR, 24'h01_2345, 10'd64, 1'b0, 600, 1'b0, gd);
    do_op("ref_after_wr", K_REF, 24'h01_2345, 10'd64, 1'b0, 1, 1'b0, gd);
    do_op("stall_rd", K_RD, 24'h02_0000, 10'd100, 1'b1, 4 * 781, 1'b0, gd);
    do_op("sat_ref1", K_REF, 24'h02_0000, 10'd100, 1'b1, 1, 1'b0, gd);
    do_op("sat_ref2", K_REF, 24'h02_0000, 10'd100, 1'b1, 1, 1'b0, gd);
    do_op("sat_ref3", K_REF, 24'h02_0000, 10'd100, 1'b1, 1, 1'b0, gd);
    do_op("post_sat", K_WR, 24'h01_2345, 10'd64, 1'b0, 2, 1'b0, gd);

    // init_done drops during a read
    wr_req = 1'b0;
    rd_addr = 24'h0A_0000; rd_burst = 10'd5;
    wait_go(50, f, g);
    chk("drop_go", 32'(g), 32'(K_RD));
    init_done = 1'b0;
    repeat (10) @(negedge clk);
    ctrl_done = 1'b1;
    @(negedge clk);
    ctrl_done = 1'b0;
    chk("drop_rd_done", 32'(rd_done), 32'(1));
    wr_req = 1'b1;
    wait_go(1000, f, g);
    chk("low_nogo", 32'(f), 32'(0));
    wr_req = 1'b0;
    init_done = 1'b1;
    do_op("rise_rd", K_RD, 24'h0A_0000, 10'd5, 1'b1, 2, 1'b0, gd);

    // asynchronous reset in the middle of a write
    wr_req = 1'b1;
    wait_go(50, f, g);
    chk("pre_rst_go", 32'(g), 32'(K_WR));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_addr", 32'(ctrl_addr), 32'(0));
    chk("arst_burst", 32'(ctrl_burst), 32'(0));
    chk("arst_rdwr", 32'(ctrl_rd_wr), 32'(0));
    chk("arst_gos", 32'(gos()), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    // last grant was WR, but reset makes the next contested grant WR again
    do_op("post_rst", K_WR, 24'h01_2345, 10'd64, 1'b0, 2, 1'b0, gd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_req_arb.md
# sdram_req_arb

SDRAM request arbiter and refresh scheduler sitting between the frame-buffer FIFOs (camera write side, display/edge-detect read side) and the SDRAM controller. It generates periodic auto-refresh requests and grants one burst at a time to the write or read requester. Refresh has priority; write and read alternate round-robin when both are pending. It presents a single latched address, burst length and read/write select to the controller.

## Interface
- REF_PERIOD, 781: clk cycles between refresh requests (7.8 us at 100 MHz).
- ADDR_W, 24: SDRAM linear address width ({bank[1:0], row[12:0], col[8:0]}).
- BURST_W, 10: burst length width in words.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- init_done  in  1  SDRAM initialisation complete; the block is inactive while low.
- wr_req  in  1  write FIFO holds at least one burst; level-sensitive.
- wr_addr  in  ADDR_W  write burst start address.
- wr_burst  in  BURST_W  write burst length.
- rd_req  in  1  read FIFO has room for one burst; level-sensitive.
- rd_addr  in  ADDR_W  read burst start address.
- rd_burst  in  BURST_W  read burst length.
- wr_done  out  1  one-cycle pulse when the granted write burst completes.
- rd_done  out  1  one-cycle pulse when the granted read burst completes.
- ctrl_rd_wr  out  1  1 = read, 0 = write; held for the whole operation.
- ctrl_addr  out  ADDR_W  latched burst address.
- ctrl_burst  out  BURST_W  latched burst length.
- ctrl_wr_go / ctrl_rd_go / ctrl_ref_go  out  1 each  one-cycle start pulses to the controller.
- ctrl_done  in  1  one-cycle pulse from the controller when the current operation finishes.

## Operation
- States: IDLE, REF, WR, RD.
- Reset values: state IDLE; all go/done outputs 0; ctrl_rd_wr 0; ctrl_addr 0; ctrl_burst 0; refresh counter 0; ref_pend 0; last_grant = RD, so the first contested grant goes to write.
- Refresh timer: counts 0..REF_PERIOD-1 only while init_done = 1.
  - On wrap it increments ref_pend, a 2-bit counter saturating at 3.
  - Entering REF decrements ref_pend.
  - Simultaneous wrap and decrement leaves ref_pend unchanged.
- IDLE arbitration, evaluated only when init_done = 1, in priority order:
  - ref_pend != 0 → REF.
  - wr_req and rd_req both valid → the one not equal to last_grant.
  - Otherwise whichever single request is valid.
- A request with burst length 0 is treated as not valid.
- On a WR or RD grant:
  - Latch addr and burst into ctrl_addr/ctrl_burst.
  - Set ctrl_rd_wr.
  - Update last_grant.
- On a REF grant, ctrl_addr, ctrl_burst and ctrl_rd_wr keep their values.
- Busy states (REF/WR/RD) wait for ctrl_done, then return to IDLE. WR pulses wr_done; RD pulses rd_done; REF pulses neither.
- ctrl_done in IDLE, or in the go cycle, is ignored.
- An operation in progress is never preempted; refresh waits for the next IDLE.
- init_done falling:
  - Counter and ref_pend clear synchronously.
  - A busy state still completes on ctrl_done.
  - No new grants are made until init_done rises again.
- Asynchronous reset mid-operation returns all state to reset values immediately.

## Timing
- Request sampled in IDLE at edge N → state and latched fields valid, and the go pulse asserted, in cycle N+1 (registered, 1-cycle latency).
- The go pulse is exactly one cycle wide.
- ctrl_done at edge M → done pulse and state IDLE in cycle M+1.
- Earliest next go is cycle M+2, giving at least one IDLE cycle between operations.
- The address and burst presented to the controller stay stable from the go cycle through the ctrl_done cycle.
- Requesters must not change wr_addr/rd_addr for a pending burst until its done pulse; they advance their address on done.

## Structure
- The shared include sdram_para.v gains:
  - Arbiter state encodings (ARB_IDLE, ARB_REF, ARB_WR, ARB_RD, 2 bits).
  - Default REF_PERIOD.
- One natural sub-module: sdram_ref_timer, containing the counter, saturating ref_pend, and the clear-on-!init_done logic. It has inputs ref_ack and init_done, and output ref_pend != 0.
- Arbiter FSM and field latches stay in the top module.

## Test plan
- Reset, then init_done=1, no requests → ctrl_ref_go at cycle 782 after init_done; ctrl_done two cycles later → back to IDLE; next refresh 781 cycles after the first wrap.
- wr_req=1 and rd_req=1 held continuously, ctrl_done 20 cycles after each go → go sequence WR, RD, WR, RD; ctrl_addr and ctrl_rd_wr match the granted side; wr_done/rd_done pulse once each.
- Refresh wrap during a 600-cycle write burst → write not interrupted; ctrl_ref_go precedes any further WR/RD grant.
- Controller stalled (no ctrl_done) for 4×REF_PERIOD → ref_pend saturates at 3; three consecutive refreshes are then issued before any data grant.
- wr_burst=0 with wr_req=1, rd_req=1 → only RD granted.
- init_done dropped during RD → rd_done still pulses on ctrl_done; no go pulses while low.
- Reset asserted mid-WR → outputs return to reset values immediately.
